// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite DMA that pauses the CPU and copies a 256-byte page to the OAM data port
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [15:0] i_CPU_ADDR,
  input  logic [7:0]  i_CPU_DATA,
  input  logic        i_CPU_R_WN,
  input  logic [7:0]  i_BUS_DATA,
  output logic        o_CPU_PAUSE,
  output logic        o_BUS_SEL,
  output logic [15:0] o_DMA_ADDR,
  output logic [7:0]  o_DMA_DATA,
  output logic        o_DMA_R_WN,
  output logic        o_BUSY
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_e;
  state_e state_q, state_d;
  logic [7:0] page_q, page_d, cnt_q, cnt_d, data_q, data_d;
  logic odd_q;
  logic trig;
  assign trig = !i_CPU_R_WN && i_CPU_ADDR == DMA_REG_ADDR && !o_CPU_PAUSE;
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (trig) begin
        state_d = HALT;
        page_d  = i_CPU_DATA;
        cnt_d   = 8'h00;
      end
      // reads must land on even cycles, so an extra dummy cycle aligns them
      HALT:  state_d = odd_q ? READ : ALIGN;
      ALIGN: state_d = READ;
      READ: begin
        state_d = WRITE;
        data_d  = i_BUS_DATA;
      end
      WRITE: begin
        state_d = (cnt_q == 8'hFF) ? IDLE : READ;
        cnt_d   = cnt_q + 8'h01;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= IDLE;
      page_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      odd_q   <= ~odd_q;
    end
  end
  assign o_CPU_PAUSE = state_q != IDLE;
  assign o_BUS_SEL   = o_CPU_PAUSE;
  assign o_BUSY      = o_CPU_PAUSE;
  assign o_DMA_ADDR  = state_q == READ ? {page_q, cnt_q} : state_q == WRITE ? OAM_DATA_ADDR : 16'h0000;
  assign o_DMA_DATA  = state_q == WRITE ? data_q : 8'h00;
  assign o_DMA_R_WN  = state_q != WRITE;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: vector table for non-trigger cases plus directed multi-cycle transfer sequences
module tb_oam_dma_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rwn, pause, bus_sel, dma_rwn, busy, odd_m;
  logic [15:0] addr, dma_addr;
  logic [7:0] data, bus_data, dma_data;
  int checks = 0;
  int errors = 0;
  oam_dma_ctrl dut (
    .i_CLK(clk), .i_RST(rst), .i_CPU_ADDR(addr), .i_CPU_DATA(data), .i_CPU_R_WN(rwn),
    .i_BUS_DATA(bus_data), .o_CPU_PAUSE(pause), .o_BUS_SEL(bus_sel), .o_DMA_ADDR(dma_addr),
    .o_DMA_DATA(dma_data), .o_DMA_R_WN(dma_rwn), .o_BUSY(busy)
  );
  // RAM image: page 2 holds i^5A, other pages are further XORed with (page^2)
  function automatic logic [7:0] ram(input logic [7:0] page, input logic [7:0] i);
    return i ^ 8'h5A ^ page ^ 8'h02;
  endfunction
  assign bus_data = (dma_rwn && bus_sel) ? ram(dma_addr[15:8], dma_addr[7:0]) : 8'hEE;
  always @(posedge clk) odd_m <= rst ? 1'b0 : ~odd_m;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic idle_outputs(input string tag);
    chk({tag, " pause"}, pause, 0);
    chk({tag, " bus_sel"}, bus_sel, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " dma_addr"}, dma_addr, 0);
    chk({tag, " dma_data"}, dma_data, 0);
    chk({tag, " dma_rwn"}, dma_rwn, 1);
  endtask
  task automatic xfer(input logic [7:0] page, input int exp_len);
    int plen = 0, wr = 0, rd = 0, dummies = 0, first_rd = -1, bad = 0;
    addr = 16'h4014; data = page; rwn = 1'b0;
    tick;
    addr = 16'h0000; data = 8'h00; rwn = 1'b1;
    for (int idx = 0; idx < 700; idx++) begin
      if (!pause) break;
      plen++;
      if (!bus_sel || !busy) bad++;
      if (!dma_rwn) begin
        if (dma_addr !== 16'h2004 || dma_data !== ram(page, wr[7:0])) bad++;
        wr++;
      end else if (dma_addr != 16'h0000) begin
        if (first_rd < 0) first_rd = idx;
        if (dma_addr !== {page, rd[7:0]} || dma_data !== 8'h00) bad++;
        rd++;
      end else begin
        if (dma_data !== 8'h00) bad++;
        dummies++;
      end
      tick;
    end
    chk($sformatf("pg%0h pause_len", page), plen, exp_len);
    chk($sformatf("pg%0h writes", page), wr, 256);
    chk($sformatf("pg%0h reads", page), rd, 256);
    chk($sformatf("pg%0h first_read_idx", page), first_rd, exp_len - 512);
    chk($sformatf("pg%0h dummy_cycles", page), dummies, exp_len - 512);
    chk($sformatf("pg%0h bad_cycles", page), bad, 0);
  endtask
  typedef struct {
    logic rst; logic [15:0] a; logic [7:0] d; logic rwn;
    logic pause; logic [15:0] ea; logic erwn;
  } vec_t;
  vec_t vecs[6];
  initial begin
    int wr, post_wr, post_pause;
    logic hit;
    vecs[0] = '{1'b0, 16'h4014, 8'h02, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{1'b0, 16'h4015, 8'h02, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{1'b1, 16'h4014, 8'h02, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{1'b0, 16'h2004, 8'h33, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{1'b0, 16'h4014, 8'h07, 1'b1, 1'b0, 16'h0000, 1'b1};
    rst = 1'b1; addr = 16'h0000; data = 8'h00; rwn = 1'b1;
    tick;
    tick;
    idle_outputs("reset");
    rst = 1'b0;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; addr = vecs[i].a; data = vecs[i].d; rwn = vecs[i].rwn;
      tick;
      chk($sformatf("vec%0d pause", i), pause, vecs[i].pause);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].pause);
      chk($sformatf("vec%0d dma_addr", i), dma_addr, vecs[i].ea);
      chk($sformatf("vec%0d dma_rwn", i), dma_rwn, vecs[i].erwn);
    end
    rst = 1'b0; addr = 16'h0000; data = 8'h00; rwn = 1'b1;
    tick;
    while (odd_m !== 1'b0) tick;
    xfer(8'h02, 513);
    while (odd_m !== 1'b1) tick;
    xfer(8'h02, 514);
    while (odd_m !== 1'b0) tick;
    xfer(8'h03, 513);
    xfer(8'h07, odd_m ? 514 : 513);
    idle_outputs("after b2b");
    wr = 0; hit = 1'b0;
    addr = 16'h4014; data = 8'h02; rwn = 1'b0;
    tick;
    addr = 16'h0000; data = 8'h00; rwn = 1'b1;
    for (int k = 0; k < 700; k++) begin
      if (!dma_rwn) wr++;
      if (wr == 100) begin
        hit = 1'b1;
        rst = 1'b1;
        tick;
        break;
      end
      tick;
    end
    chk("mid reset reached 100th write", hit, 1);
    idle_outputs("mid reset");
    rst = 1'b0;
    post_wr = 0; post_pause = 0;
    for (int k = 0; k < 600; k++) begin
      tick;
      if (!dma_rwn) post_wr++;
      if (pause) post_pause++;
    end
    chk("post reset writes", post_wr, 0);
    chk("post reset pause cycles", post_pause, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
